// File: rtl/weight_seq_pkg.sv
// rtl/weight_seq_pkg.sv - shared types and widths for the weight sequencer
package weight_seq_pkg;

  localparam int WR_CNT_W = 26;
  localparam int RD_CNT_W = 20;
  localparam int WORD_W   = 72;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    LOAD,
    LWAIT,
    ARM,
    READ,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/weight_sequencer.sv
// rtl/weight_sequencer.sv - loads one layer of weights into the manager and replays them per tile
module weight_sequencer
  import weight_seq_pkg::*;
#(
  parameter int CI_W   = 10,
  parameter int CO_W   = 10,
  parameter int PASS_W = 16,
  parameter int RD_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CI_W-1:0]   cfg_ci_groups,
  input  logic [CO_W-1:0]   cfg_co_groups,
  input  logic [PASS_W-1:0] cfg_num_passes,
  input  logic [WORD_W-1:0] s_wdata,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic              wm_write_mode,
  output logic              wm_data_valid,
  output logic [WORD_W-1:0] wm_data_in,
  input  logic              wm_write_complete,
  output logic              wm_read_en,
  input  logic              wm_read_complete,
  input  logic              cons_ready,
  output logic              pass_start,
  output logic              pass_done,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  state_e              state_q;
  logic [CI_W-1:0]     ci_q;
  logic [CO_W-1:0]     co_q;
  logic [PASS_W-1:0]   passes_q;
  logic [PASS_W-1:0]   pass_rem_q;
  logic [WR_CNT_W-1:0] wr_total_q;
  logic [RD_CNT_W-1:0] rd_total_q;
  logic [WR_CNT_W-1:0] wr_cnt_q;
  logic [RD_CNT_W-1:0] rd_cnt_q;
  logic [7:0]          drain_cnt_q;
  logic                pass_start_q;
  logic                pass_done_q;
  logic                done_q;
  logic                cfg_err_q;

  logic [WR_CNT_W-1:0] wr_total_d;
  logic [RD_CNT_W-1:0] rd_total_d;
  logic [WR_CNT_W-1:0] wr_cnt_d;
  logic [RD_CNT_W-1:0] rd_last;
  logic                beat;
  logic                cfg_zero;

  // Products are formed from the latched config and captured in CALC, keeping the multiply off the start path.
  assign wr_total_d = WR_CNT_W'({ci_q, 3'b000}) * WR_CNT_W'({co_q, 3'b000});
  assign rd_total_d = RD_CNT_W'(ci_q) * RD_CNT_W'(co_q);
  assign wr_cnt_d   = wr_cnt_q + WR_CNT_W'(1);
  assign rd_last    = rd_total_q - RD_CNT_W'(1);
  assign cfg_zero   = (cfg_ci_groups == '0) || (cfg_co_groups == '0) || (cfg_num_passes == '0);

  // Stream and manager handshakes are plain decodes of the state register.
  assign s_wready      = (state_q == LOAD);
  assign wm_write_mode = (state_q == LOAD) || (state_q == LWAIT);
  assign wm_read_en    = (state_q == READ);
  assign wm_data_valid = s_wvalid & s_wready;
  assign wm_data_in    = s_wdata;
  assign beat          = wm_data_valid;
  assign busy          = (state_q != IDLE);
  assign pass_start    = pass_start_q;
  assign pass_done     = pass_done_q;
  assign done          = done_q;
  assign cfg_err       = cfg_err_q;

  // Layer sequencing: load once, then replay the full weight set once per remaining pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ci_q         <= '0;
      co_q         <= '0;
      passes_q     <= '0;
      pass_rem_q   <= '0;
      wr_total_q   <= '0;
      rd_total_q   <= '0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      drain_cnt_q  <= '0;
      pass_start_q <= 1'b0;
      pass_done_q  <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      pass_start_q <= 1'b0;
      pass_done_q  <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            ci_q      <= cfg_ci_groups;
            co_q      <= cfg_co_groups;
            passes_q  <= cfg_num_passes;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            cfg_err_q <= cfg_zero;
            state_q   <= cfg_zero ? DONE : CALC;
          end
        end
        CALC: begin
          wr_total_q <= wr_total_d;
          rd_total_q <= rd_total_d;
          state_q    <= LOAD;
        end
        LOAD: begin
          if (beat) begin
            wr_cnt_q <= wr_cnt_d;
            if (wr_cnt_d == wr_total_q) state_q <= LWAIT;
          end
        end
        LWAIT: begin
          // write_mode must stay up until the manager confirms; dropping it clears its counters.
          if (wm_write_complete) begin
            pass_rem_q <= passes_q;
            state_q    <= ARM;
          end
        end
        ARM: begin
          if (pass_rem_q == '0) begin
            state_q <= DONE;
          end else if (cons_ready) begin
            rd_cnt_q     <= '0;
            pass_start_q <= 1'b1;
            state_q      <= READ;
          end
        end
        READ: begin
          rd_cnt_q    <= rd_cnt_q + RD_CNT_W'(1);
          drain_cnt_q <= '0;
          if (rd_cnt_q == rd_last) state_q <= DRAIN;
        end
        DRAIN: begin
          if (drain_cnt_q != 8'hff) drain_cnt_q <= drain_cnt_q + 8'd1;
          if (wm_read_complete) begin
            pass_done_q <= 1'b1;
            pass_rem_q  <= pass_rem_q - PASS_W'(1);
            state_q     <= ARM;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Manager strobes outside their waiting state, or a read_complete later than the pipe depth, indicate a broken handshake.
  a_wc_state: assert property (@(posedge clk) disable iff (rst) wm_write_complete |-> (state_q == LWAIT));
  a_rc_state: assert property (@(posedge clk) disable iff (rst) wm_read_complete |-> (state_q == DRAIN));
  a_rc_late:  assert property (@(posedge clk) disable iff (rst) (state_q == DRAIN) |-> (drain_cnt_q < 8'(RD_LAT)));

endmodule

// File: tb/tb_weight_sequencer.sv
// tb/tb_weight_sequencer.sv - self-checking bench for weight_sequencer
module tb_weight_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  cfg_ci_groups;
  logic [9:0]  cfg_co_groups;
  logic [15:0] cfg_num_passes;
  logic [71:0] s_wdata;
  logic        s_wvalid;
  logic        s_wready;
  logic        wm_write_mode;
  logic        wm_data_valid;
  logic [71:0] wm_data_in;
  logic        wm_write_complete;
  logic        wm_read_en;
  logic        wm_read_complete;
  logic        cons_ready;
  logic        pass_start;
  logic        pass_done;
  logic        busy;
  logic        done;
  logic        cfg_err;

  weight_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_ci_groups(cfg_ci_groups), .cfg_co_groups(cfg_co_groups), .cfg_num_passes(cfg_num_passes),
    .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .wm_write_mode(wm_write_mode), .wm_data_valid(wm_data_valid), .wm_data_in(wm_data_in),
    .wm_write_complete(wm_write_complete), .wm_read_en(wm_read_en), .wm_read_complete(wm_read_complete),
    .cons_ready(cons_ready), .pass_start(pass_start), .pass_done(pass_done),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // expectations for the layer in flight, used by the manager model and the monitor
  int exp_total = 0;
  int exp_run   = 0;
  int vmode     = 0;
  int cwait_cfg = 0;
  int cwait     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural weight manager: write_complete after the last expected beat, read_complete 4 cycles after the last read_en.
  int         mw_cnt = 0;
  logic [3:0] rd_sh  = 4'b0;
  initial wm_write_complete = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      mw_cnt <= 0;
      rd_sh <= 4'b0;
      wm_write_complete <= 1'b0;
    end else begin
      rd_sh <= {rd_sh[2:0], wm_read_en};
      wm_write_complete <= wm_write_mode && wm_data_valid && (mw_cnt + 1 == exp_total);
      if (!wm_write_mode) mw_cnt <= 0;
      else if (wm_data_valid) mw_cnt <= mw_cnt + 1;
    end
  end
  assign wm_read_complete = rd_sh[3] & ~rd_sh[2];

  // Cumulative monitor; tests take differences between snapshots.
  int c_wready = 0, c_dv = 0, c_wm = 0, c_rd = 0, c_ps = 0, c_pd = 0, c_done = 0;
  int e_late = 0, e_dvnowm = 0, e_data = 0, e_run = 0, e_ps = 0, e_lat = 0;
  int lay_dv = 0, run = 0, last_rd_cyc = 0, start_cyc = 0, done_cyc = 0, pd_cyc = 0;
  int wc_cyc = 0, last_wm_cyc = 0;
  always @(negedge clk) begin
    if (start && !busy && !rst) begin lay_dv = 0; start_cyc = cyc; end
    if (exp_total > 0 && s_wready && lay_dv >= exp_total) e_late++;
    if (wm_data_valid) begin c_dv++; lay_dv++; end
    if (wm_data_valid && !wm_write_mode) e_dvnowm++;
    if (wm_data_in !== s_wdata) e_data++;
    if (s_wready) c_wready++;
    if (wm_write_mode) begin c_wm++; last_wm_cyc = cyc; end
    if (wm_write_complete) wc_cyc = cyc;
    if (pass_start) c_ps++;
    if (pass_start && (!wm_read_en || run != 0)) e_ps++;
    if (wm_read_en) begin
      if (run == 0 && !pass_start) e_ps++;
      c_rd++; run++; last_rd_cyc = cyc;
    end else if (run > 0) begin
      if (run != exp_run) e_run++;
      run = 0;
    end
    if (pass_done) begin
      c_pd++; pd_cyc = cyc;
      if (cyc - last_rd_cyc != 5) e_lat++;
    end
    if (done) begin c_done++; done_cyc = cyc; end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // One clock of stimulus, driven just after the rising edge.
  task automatic tick(input logic st);
    @(posedge clk); #1;
    start = st;
    case (vmode)
      0: s_wvalid = 1'b1;
      1: s_wvalid = ~s_wvalid;
      default: s_wvalid = 1'($urandom_range(0, 1));
    endcase
    s_wdata = {8'($urandom), 32'($urandom), 32'($urandom)};
    if (wm_write_complete || wm_read_complete) cwait = 0;
    else if (cwait < 1000) cwait++;
    cons_ready = (cwait >= cwait_cfg);
  endtask

  function automatic logic [8:0] ctl_outs();
    return {busy, s_wready, wm_write_mode, wm_read_en, wm_data_valid, pass_start, pass_done, done, cfg_err};
  endfunction

  typedef struct {
    string nm;
    int ci, co, p, vm, cw, inj;
    int e_beats, e_rd, e_ps, e_err;
  } vec_t;

  task automatic run_layer(input vec_t v);
    int d_wr, d_dv, d_wm, d_rd, d_ps, d_pd, d_done, d_err, t;
    bit injd;
    exp_total = 64 * v.ci * v.co;
    exp_run   = v.ci * v.co;
    vmode     = v.vm;
    cwait_cfg = v.cw;
    d_wr = c_wready; d_dv = c_dv; d_wm = c_wm; d_rd = c_rd; d_ps = c_ps; d_pd = c_pd; d_done = c_done;
    d_err = e_late + e_dvnowm + e_data + e_run + e_ps + e_lat;
    cfg_ci_groups  = 10'(v.ci);
    cfg_co_groups  = 10'(v.co);
    cfg_num_passes = 16'(v.p);
    tick(1'b1);
    t = 0; injd = 0;
    while ((c_done - d_done) == 0 && t < 5000) begin
      if (v.inj > 0 && !injd && (c_dv - d_dv) == v.inj) begin
        injd = 1;
        cfg_ci_groups = 10'd3; cfg_co_groups = 10'd3; cfg_num_passes = 16'd2;
        tick(1'b1);
      end else begin
        tick(1'b0);
      end
      t++;
    end
    tick(1'b0);
    tick(1'b0);
    check({v.nm, "_finished"}, longint'(t < 5000), 1);
    check({v.nm, "_beats"}, c_dv - d_dv, v.e_beats);
    check({v.nm, "_read_cycles"}, c_rd - d_rd, v.e_rd);
    check({v.nm, "_pass_starts"}, c_ps - d_ps, v.e_ps);
    check({v.nm, "_pass_dones"}, c_pd - d_pd, v.e_ps);
    check({v.nm, "_done_pulses"}, c_done - d_done, 1);
    check({v.nm, "_cfg_err"}, cfg_err, v.e_err);
    check({v.nm, "_busy_after"}, busy, 0);
    check({v.nm, "_protocol_errs"}, e_late + e_dvnowm + e_data + e_run + e_ps + e_lat - d_err, 0);
    if (v.vm == 0) check({v.nm, "_wready_cycles"}, c_wready - d_wr, v.e_beats);
    if (v.e_err != 0) begin
      check({v.nm, "_done_latency"}, done_cyc - start_cyc, 2);
      check({v.nm, "_write_mode_cycles"}, c_wm - d_wm, 0);
    end else begin
      check({v.nm, "_wm_held_to_wc"}, last_wm_cyc, wc_cyc);
      check({v.nm, "_done_after_pd"}, longint'(done_cyc > pd_cyc), 1);
    end
  endtask

  vec_t vecs[8];

  initial begin
    int t, ps0, ci, co, p;
    vec_t rv;
    vecs[0] = '{"minimal",   1, 1, 1, 0, 0,  0,  64,  1, 1, 0};
    vecs[1] = '{"throttled", 2, 1, 1, 1, 0,  0, 128,  2, 1, 0};
    vecs[2] = '{"multipass", 3, 2, 4, 0, 10, 0, 384, 24, 4, 0};
    vecs[3] = '{"zero_co",   1, 0, 1, 0, 0,  0,   0,  0, 0, 1};
    vecs[4] = '{"zero_ci",   0, 3, 2, 0, 0,  0,   0,  0, 0, 1};
    vecs[5] = '{"zero_pass", 1, 1, 0, 0, 0,  0,   0,  0, 0, 1};
    vecs[6] = '{"random_v",  2, 2, 2, 2, 3,  0, 256,  8, 2, 0};
    vecs[7] = '{"start_busy",1, 1, 1, 0, 0,  10, 64,  1, 1, 0};

    rst = 1'b1; start = 1'b0; s_wvalid = 1'b0; s_wdata = '0; cons_ready = 1'b0;
    cfg_ci_groups = '0; cfg_co_groups = '0; cfg_num_passes = '0;
    repeat (3) tick(1'b0);
    @(negedge clk);
    check("reset_outputs", ctl_outs(), 0);
    check("reset_data_passthru", longint'(wm_data_in === s_wdata), 1);
    tick(1'b0);
    rst = 1'b0;
    tick(1'b0);
    check("idle_outputs", ctl_outs(), 0);

    for (int i = 0; i < 8; i++) run_layer(vecs[i]);

    // randomized layers against plain arithmetic expectations
    for (int i = 0; i < 4; i++) begin
      ci = $urandom_range(1, 3); co = $urandom_range(1, 3); p = $urandom_range(1, 3);
      rv = '{$sformatf("rand%0d", i), ci, co, p, 2, $urandom_range(0, 5), 0,
             64 * ci * co, ci * co * p, p, 0};
      run_layer(rv);
    end

    // reset on the 3rd read_en cycle of pass 2
    exp_total = 256; exp_run = 4; vmode = 0; cwait_cfg = 0;
    cfg_ci_groups = 10'd2; cfg_co_groups = 10'd2; cfg_num_passes = 16'd3;
    ps0 = c_ps;
    tick(1'b1);
    t = 0;
    while (!((c_ps - ps0) == 2 && run == 2) && t < 5000) begin tick(1'b0); t++; end
    check("midread_reached", longint'(t < 5000), 1);
    check("midread_read_en_live", wm_read_en, 1);
    rst = 1'b1;
    tick(1'b0);
    check("midread_reset_outputs", ctl_outs(), 0);
    rst = 1'b0;
    tick(1'b0);
    check("midread_idle", busy, 0);
    run_layer('{"post_reset", 1, 2, 2, 2, 2, 0, 128, 4, 2, 0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
